sort_floats_serial: RTL and testbench

//  Sequential counterpart to the combinational float sorters.
//  - Accepts N floats one per handshake on the up side, then sorts them in place with a

---
 rtl/sort_floats_serial_pkg.sv | 14 +
 rtl/f_less_or_equal.sv | 39 +++
 rtl/sort_floats_serial.sv | 180 ++++++++++++++++++
 tb/tb_sort_floats_serial.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_floats_serial_pkg.sv
// Shared definitions for the serial float sorter and its testbench.
package sort_floats_serial_pkg;

  // IEEE-754 single precision word layout.
  localparam int FLEN  = 32;
  localparam int EXP_W = 8;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SORT    = 2'd1,
    EMIT    = 2'd2
  } state_e;

endpackage

// File: rtl/f_less_or_equal.sv
// Float comparator: res = (a <= b) for IEEE-754 words, with +0 == -0.
// err flags a NaN or Inf operand; res is still produced but is then meaningless.
module f_less_or_equal
  import sort_floats_serial_pkg::*;
(
  input  logic [FLEN-1:0] a,
  input  logic [FLEN-1:0] b,
  output logic            res,
  output logic            err
);

  logic            sign_a_s;
  logic            sign_b_s;
  logic [FLEN-2:0] mag_a_s;
  logic [FLEN-2:0] mag_b_s;

  assign sign_a_s = a[FLEN-1];
  assign sign_b_s = b[FLEN-1];
  assign mag_a_s  = a[FLEN-2:0];
  assign mag_b_s  = b[FLEN-2:0];

  // An all-ones exponent means NaN or Inf on either side.
  assign err = (&a[FLEN-2 -: EXP_W]) | (&b[FLEN-2 -: EXP_W]);

  // Sign decides first; equal signs compare magnitude, reversed for negatives.
  always_comb begin
    res = 1'b1;
    if ((mag_a_s == {(FLEN-1){1'b0}}) && (mag_b_s == {(FLEN-1){1'b0}})) begin
      res = 1'b1;
    end else if (sign_a_s != sign_b_s) begin
      res = sign_a_s;
    end else if (sign_a_s) begin
      res = (mag_a_s >= mag_b_s);
    end else begin
      res = (mag_a_s <= mag_b_s);
    end
  end

endmodule

// File: rtl/sort_floats_serial.sv
// Serial float sorter: collects N words, bubble-sorts them in place with one
// shared comparator (one compare per clock), then streams them out ascending.
module sort_floats_serial
  import sort_floats_serial_pkg::*;
#(
  parameter int N = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            up_valid,
  input  logic [FLEN-1:0] up_data,
  output logic            up_ready,
  output logic            down_valid,
  output logic [FLEN-1:0] down_data,
  output logic            down_last,
  output logic            down_err,
  input  logic            down_ready
);

  localparam int            CW       = $clog2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [CW-1:0] LAST_J   = CW'(N - 2);
  localparam logic [CW-1:0] ONE      = CW'(1);

  state_e          state_r;
  state_e          state_s;
  logic [FLEN-1:0] buf_r [N];
  logic [CW-1:0]   wr_cnt_r;
  logic [CW-1:0]   rd_cnt_r;
  logic [CW-1:0]   p_r;
  logic [CW-1:0]   j_r;
  logic            err_sticky_r;
  logic            down_valid_r;
  logic [FLEN-1:0] down_data_r;
  logic            down_last_r;
  logic            down_err_r;

  logic [FLEN-1:0] cmp_a_s;
  logic [FLEN-1:0] cmp_b_s;
  logic            cmp_res_s;
  logic            cmp_err_s;
  logic            up_fire_s;
  logic            down_fire_s;
  logic            sort_done_s;
  logic [CW-1:0]   rd_next_s;

  assign cmp_a_s     = buf_r[j_r];
  assign cmp_b_s     = buf_r[j_r + ONE];
  assign up_fire_s   = up_valid && (state_r == COLLECT);
  assign down_fire_s = down_valid_r && down_ready;
  assign sort_done_s = (state_r == SORT) && (p_r == LAST_J) && (j_r == LAST_J);
  assign rd_next_s   = rd_cnt_r + ONE;

  assign up_ready   = (state_r == COLLECT);
  assign down_valid = down_valid_r;
  assign down_data  = down_data_r;
  assign down_last  = down_last_r;
  assign down_err   = down_err_r;

  f_less_or_equal u_cmp (
    .a   (cmp_a_s),
    .b   (cmp_b_s),
    .res (cmp_res_s),
    .err (cmp_err_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= COLLECT;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state: full set -> sort; fixed-length sort -> emit; last word out -> collect.
  always_comb begin
    state_s = state_r;
    case (state_r)
      COLLECT: begin
        if (up_fire_s && (wr_cnt_r == LAST_IDX)) begin
          state_s = SORT;
        end else begin
          state_s = COLLECT;
        end
      end
      SORT: begin
        if (sort_done_s) begin
          state_s = EMIT;
        end else begin
          state_s = SORT;
        end
      end
      EMIT: begin
        if (down_fire_s && down_last_r) begin
          state_s = COLLECT;
        end else begin
          state_s = EMIT;
        end
      end
      default: state_s = COLLECT;
    endcase
  end

  // Buffer, counters, sticky error and the registered output word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        buf_r[i] <= {FLEN{1'b0}};
      end
      wr_cnt_r     <= {CW{1'b0}};
      rd_cnt_r     <= {CW{1'b0}};
      p_r          <= {CW{1'b0}};
      j_r          <= {CW{1'b0}};
      err_sticky_r <= 1'b0;
      down_valid_r <= 1'b0;
      down_data_r  <= {FLEN{1'b0}};
      down_last_r  <= 1'b0;
      down_err_r   <= 1'b0;
    end else begin
      case (state_r)
        COLLECT: begin
          if (up_fire_s) begin
            buf_r[wr_cnt_r] <= up_data;
            if (wr_cnt_r == LAST_IDX) begin
              wr_cnt_r     <= {CW{1'b0}};
              p_r          <= {CW{1'b0}};
              j_r          <= {CW{1'b0}};
              err_sticky_r <= 1'b0;
            end else begin
              wr_cnt_r <= wr_cnt_r + ONE;
            end
          end
        end
        SORT: begin
          err_sticky_r <= err_sticky_r | cmp_err_s;
          // res=0 means a > b: swap; equal values hold, keeping the sort stable.
          if (!cmp_res_s) begin
            buf_r[j_r]       <= cmp_b_s;
            buf_r[j_r + ONE] <= cmp_a_s;
          end
          if (j_r == LAST_J) begin
            j_r <= {CW{1'b0}};
            if (p_r == LAST_J) begin
              rd_cnt_r <= {CW{1'b0}};
            end else begin
              p_r <= p_r + ONE;
            end
          end else begin
            j_r <= j_r + ONE;
          end
        end
        EMIT: begin
          if (!down_valid_r) begin
            // First cycle in EMIT: present word 0.
            down_valid_r <= 1'b1;
            down_data_r  <= buf_r[rd_cnt_r];
            down_last_r  <= (rd_cnt_r == LAST_IDX);
            down_err_r   <= err_sticky_r;
          end else if (down_fire_s) begin
            if (down_last_r) begin
              down_valid_r <= 1'b0;
              down_data_r  <= {FLEN{1'b0}};
              down_last_r  <= 1'b0;
              down_err_r   <= 1'b0;
            end else begin
              rd_cnt_r    <= rd_next_s;
              down_data_r <= buf_r[rd_next_s];
              down_last_r <= (rd_next_s == LAST_IDX);
            end
          end
        end
        default: begin
          down_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_floats_serial.sv
// Self-checking bench for sort_floats_serial (N=3): directed table, hand-written
// corner sequences, and random sets checked against a stable-sort reference.
module tb_sort_floats_serial;
  import sort_floats_serial_pkg::*;

  localparam int NB = 3;

  typedef logic [31:0] w3_t [NB];
  typedef struct {
    w3_t  vin;
    w3_t  vexp;
    logic err;
  } vec_t;

  logic            clk;
  logic            rst;
  logic            up_valid;
  logic [FLEN-1:0] up_data;
  logic            up_ready;
  logic            down_valid;
  logic [FLEN-1:0] down_data;
  logic            down_last;
  logic            down_err;
  logic            down_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  sort_floats_serial #(.N(NB)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_data    (up_data),
    .up_ready   (up_ready),
    .down_valid (down_valid),
    .down_data  (down_data),
    .down_last  (down_last),
    .down_err   (down_err),
    .down_ready (down_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Ordering key: sign-magnitude to signed integer, +0 and -0 map to the same key.
  function automatic longint fkey(input logic [31:0] f);
    longint m;
    m = longint'(f[30:0]);
    return f[31] ? -m : m;
  endfunction

  // Reference: stable insertion sort by numeric value.
  function automatic w3_t ref_sort(input w3_t a);
    w3_t r;
    logic [31:0] t;
    int k;
    r = a;
    for (int i = 1; i < NB; i++) begin
      t = r[i];
      k = i - 1;
      while (k >= 0 && fkey(r[k]) > fkey(t)) begin
        r[k+1] = r[k];
        k--;
      end
      r[k+1] = t;
    end
    return r;
  endfunction

  task automatic send_word(input logic [31:0] w, input int gap);
    int cnt;
    if (gap > 0) begin
      up_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    up_valid = 1'b1;
    up_data  = w;
    cnt = 0;
    @(negedge clk);
    while (!up_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("send_timeout", 64'(cnt >= 100), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic recv_word(output logic [31:0] d, output logic l, output logic e, input bit rnd);
    int cnt;
    cnt = 0;
    d = 32'd0; l = 1'b0; e = 1'b0;
    forever begin
      @(negedge clk);
      down_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cnt++;
      if ((down_valid && down_ready) || cnt >= 200) break;
    end
    check("recv_timeout", 64'(cnt >= 200), 64'd0);
    d = down_data;
    l = down_last;
    e = down_err;
  endtask

  // Send one set, receive it, and compare; chk_data=0 skips the word order check.
  task automatic run_set(input string tag, input w3_t vin, input w3_t vexp, input logic eerr,
                         input bit chk_data, input bit rnd);
    logic [31:0] d;
    logic l, e;
    for (int i = 0; i < NB; i++) send_word(vin[i], rnd ? int'($urandom_range(0, 2)) : 0);
    up_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      recv_word(d, l, e, rnd);
      if (chk_data) check($sformatf("%s_data%0d", tag, i), 64'(d), 64'(vexp[i]));
      check($sformatf("%s_last%0d", tag, i), 64'(l), 64'(i == NB - 1));
      check($sformatf("%s_err%0d", tag, i), 64'(e), 64'(eerr));
    end
    @(posedge clk);
    #1;
    down_ready = 1'b0;
  endtask

  // Wait for down_valid with down_ready low; returns cycles since t0.
  task automatic wait_valid(input int t0, output int lat);
    int cnt;
    cnt = 0;
    @(negedge clk);
    while (!down_valid && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("valid_timeout", 64'(cnt >= 100), 64'd0);
    lat = cyc - t0;
  endtask

  vec_t vecs[5];

  initial begin
    w3_t rin, rexp, hin, hexp;
    logic [31:0] d, held;
    logic l, e;
    int t0, lat;

    // Table: inputs and expected ascending outputs.
    vecs[0] = '{vin: '{32'h40400000, 32'h3F800000, 32'h40000000},
                vexp: '{32'h3F800000, 32'h40000000, 32'h40400000}, err: 1'b0};
    vecs[1] = '{vin: '{32'hBF800000, 32'h80000000, 32'h3F800000},
                vexp: '{32'hBF800000, 32'h80000000, 32'h3F800000}, err: 1'b0};
    vecs[2] = '{vin: '{32'h40000000, 32'h40000000, 32'h3F800000},
                vexp: '{32'h3F800000, 32'h40000000, 32'h40000000}, err: 1'b0};
    vecs[3] = '{vin: '{32'h00000000, 32'h80000000, 32'hBF800000},
                vexp: '{32'hBF800000, 32'h00000000, 32'h80000000}, err: 1'b0};
    vecs[4] = '{vin: '{32'h3F000000, 32'hC0000000, 32'h40800000},
                vexp: '{32'hC0000000, 32'h3F000000, 32'h40800000}, err: 1'b0};

    rst = 1'b0; up_valid = 1'b0; up_data = 32'd0; down_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_up_ready", 64'(up_ready), 64'd1);
    check("rst_down_valid", 64'(down_valid), 64'd0);
    check("rst_down_data", 64'(down_data), 64'd0);
    check("rst_down_last", 64'(down_last), 64'd0);
    check("rst_down_err", 64'(down_err), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Latency: 3.0, 1.0, 2.0 back-to-back, first down_valid 5 cycles later.
    hin = '{32'h40400000, 32'h3F800000, 32'h40000000};
    hexp = '{32'h3F800000, 32'h40000000, 32'h40400000};
    for (int i = 0; i < NB; i++) send_word(hin[i], 0);
    t0 = cyc;
    up_valid = 1'b0;
    wait_valid(t0, lat);
    check("latency", 64'(lat), 64'd5);
    for (int i = 0; i < NB; i++) begin
      recv_word(d, l, e, 1'b0);
      check($sformatf("lat_data%0d", i), 64'(d), 64'(hexp[i]));
    end
    @(posedge clk); #1; down_ready = 1'b0;

    // Directed table.
    for (int v = 0; v < 5; v++)
      run_set($sformatf("vec%0d", v), vecs[v].vin, vecs[v].vexp, vecs[v].err, 1'b1, 1'b0);

    // Quiet NaN in the set: err on all words, then a clean set clears it.
    hin = '{32'h3F800000, 32'h7FC00000, 32'h40000000};
    run_set("nan", hin, hin, 1'b1, 1'b0, 1'b0);
    run_set("after_nan", vecs[0].vin, vecs[0].vexp, 1'b0, 1'b1, 1'b0);

    // Back-pressure: down_ready low for 10 cycles, with junk offered upstream.
    for (int i = 0; i < NB; i++) send_word(vecs[0].vin[i], 0);
    up_valid = 1'b0;
    wait_valid(cyc, lat);
    held = down_data;
    check("hold_first", 64'(held), 64'(vecs[0].vexp[0]));
    up_valid = 1'b1; up_data = 32'h41200000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("hold_data_c%0d", c), 64'(down_data), 64'(held));
      check($sformatf("hold_up_ready_c%0d", c), 64'(up_ready), 64'd0);
      check($sformatf("hold_valid_c%0d", c), 64'(down_valid), 64'd1);
    end
    up_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      recv_word(d, l, e, 1'b0);
      check($sformatf("hold_data%0d", i), 64'(d), 64'(vecs[0].vexp[i]));
      check($sformatf("hold_last%0d", i), 64'(l), 64'(i == NB - 1));
    end
    @(posedge clk); #1; down_ready = 1'b0;

    // Reset mid-set after two inputs; the next set must show no stale data.
    send_word(32'h41200000, 0);
    send_word(32'h3F000000, 0);
    up_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_up_ready", 64'(up_ready), 64'd1);
    check("midrst_down_valid", 64'(down_valid), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    hin = '{32'h40A00000, 32'h40800000, 32'h40C00000};
    hexp = '{32'h40800000, 32'h40A00000, 32'h40C00000};
    run_set("midrst", hin, hexp, 1'b0, 1'b1, 1'b0);

    // Random finite sets with random gaps and back-pressure.
    for (int s = 0; s < 30; s++) begin
      for (int i = 0; i < NB; i++) begin
        case ($urandom_range(0, 5))
          0: rin[i] = (i > 0) ? rin[i-1] : 32'h00000000;
          1: rin[i] = {1'($urandom_range(0, 1)), 31'd0};
          default: rin[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)), 23'($urandom)};
        endcase
      end
      rexp = ref_sort(rin);
      run_set($sformatf("rnd%0d", s), rin, rexp, 1'b0, 1'b1, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
